// File: rtl/serial_host_link.sv
// Host end of the 6-phase serial link: sends request frames in phases 0-3 and collects 24-bit responses in phases 4-5.
// A request accepted in phase 5 is sent in the next frame; its response is queued at that frame's end. The FIFO drops and flags when full.
module serial_host_link #(
   parameter int FIFO_DEPTH  = 2,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_cpu_valid,
   input  logic [3:0]             req_cpu_command,
   input  logic [3:0]             req_cpu_wr_data,
   input  logic [23:0]            req_cpu_addr,
   input  logic                   req_mem_req_ready,
   input  logic                   req_mem_resp_valid,
   input  logic                   req_mem_resp_data,
   output logic [11:0]            link_out,
   input  logic [11:0]            link_in,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [20:0]            resp_word,
   output logic                   resp_had_req,
   output logic [2:0]             phase,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   ovf_err,
   output logic                   pad_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      PH0 = 3'd0,
      PH1 = 3'd1,
      PH2 = 3'd2,
      PH3 = 3'd3,
      PH4 = 3'd4,
      PH5 = 3'd5
   } phase_t;

   phase_t phase_q, phase_d;

   logic [3:0]  frm_cpu_valid, frm_cpu_command, frm_cpu_wr_data;
   logic [23:0] frm_cpu_addr;
   logic [2:0]  frm_mem;
   logic        cur_req;

   logic [3:0]  nxt_cpu_valid, nxt_cpu_command, nxt_cpu_wr_data;
   logic [23:0] nxt_cpu_addr;
   logic [2:0]  nxt_mem;
   logic        nxt_req;
   logic [11:0] link_out_d;

   logic [11:0] rx_low;
   logic [23:0] rx_word;
   logic        frame_end;
   logic        accept;

   logic [21:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic        full, pop, wr_en, drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) phase_q <= PH0;
      else          phase_q <= phase_d;
   end

   always_comb begin
      phase_d = PH0;
      case (phase_q)
         PH0:     phase_d = PH1;
         PH1:     phase_d = PH2;
         PH2:     phase_d = PH3;
         PH3:     phase_d = PH4;
         PH4:     phase_d = PH5;
         PH5:     phase_d = PH0;
         default: phase_d = PH0;
      endcase
   end

   assign phase     = phase_q;
   assign req_ready = (phase_q == PH5);
   assign accept    = req_valid && req_ready;
   assign frame_end = (phase_q == PH5);

   // Frame contents as they will be after this edge; phase-0 drive needs the freshly loaded frame.
   always_comb begin
      nxt_cpu_valid   = frm_cpu_valid;
      nxt_cpu_command = frm_cpu_command;
      nxt_cpu_wr_data = frm_cpu_wr_data;
      nxt_cpu_addr    = frm_cpu_addr;
      nxt_mem         = frm_mem;
      nxt_req         = cur_req;
      if (frame_end) begin
         if (accept) begin
            nxt_cpu_valid   = req_cpu_valid;
            nxt_cpu_command = req_cpu_command;
            nxt_cpu_wr_data = req_cpu_wr_data;
            nxt_cpu_addr    = req_cpu_addr;
            nxt_mem         = {req_mem_req_ready, req_mem_resp_valid, req_mem_resp_data};
            nxt_req         = 1'b1;
         end else begin
            nxt_cpu_valid   = '0;
            nxt_cpu_command = '0;
            nxt_cpu_wr_data = '0;
            nxt_cpu_addr    = '0;
            nxt_mem         = '0;
            nxt_req         = 1'b0;
         end
      end
   end

   always_comb begin
      link_out_d = '0;
      case (phase_d)
         PH0:     link_out_d = {nxt_cpu_valid, nxt_cpu_command, nxt_cpu_wr_data};
         PH1:     link_out_d = nxt_cpu_addr[11:0];
         PH2:     link_out_d = nxt_cpu_addr[23:12];
         PH3:     link_out_d = {9'b0, nxt_mem};
         default: link_out_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frm_cpu_valid   <= '0;
         frm_cpu_command <= '0;
         frm_cpu_wr_data <= '0;
         frm_cpu_addr    <= '0;
         frm_mem         <= '0;
         cur_req         <= 1'b0;
         link_out        <= '0;
      end else begin
         frm_cpu_valid   <= nxt_cpu_valid;
         frm_cpu_command <= nxt_cpu_command;
         frm_cpu_wr_data <= nxt_cpu_wr_data;
         frm_cpu_addr    <= nxt_cpu_addr;
         frm_mem         <= nxt_mem;
         cur_req         <= nxt_req;
         link_out        <= link_out_d;
      end
   end

   assign rx_word = {link_in, rx_low};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_low    <= '0;
         frame_cnt <= '0;
         pad_err   <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         if (phase_q == PH4) rx_low <= link_in;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (|rx_word[23:21]) pad_err <= 1'b1;
         end
         if (drop) ovf_err <= 1'b1;
      end
   end

   // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
   assign full       = (count == CW'(FIFO_DEPTH));
   assign resp_valid = (count != '0);
   assign pop        = resp_valid && resp_ready;
   assign wr_en      = frame_end && (!full || pop);
   assign drop       = frame_end && full && !pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (wr_en) begin
            fifo_mem[wr_ptr] <= {cur_req, rx_word[20:0]};
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign resp_word    = resp_valid ? fifo_mem[rd_ptr][20:0] : '0;
   assign resp_had_req = resp_valid ? fifo_mem[rd_ptr][21] : 1'b0;

endmodule

// File: tb/tb_serial_host_link.sv
// Directed bench for serial_host_link: framing, response capture, FIFO overflow, mid-frame reset, counter wrap.
module tb_serial_host_link;

   localparam int CW = 8;

   logic          clk;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_cpu_valid, req_cpu_command, req_cpu_wr_data;
   logic [23:0]   req_cpu_addr;
   logic          req_mem_req_ready, req_mem_resp_valid, req_mem_resp_data;
   logic [11:0]   link_out;
   logic [11:0]   link_in;
   logic          resp_valid;
   logic          resp_ready;
   logic [20:0]   resp_word;
   logic          resp_had_req;
   logic [2:0]    phase;
   logic [CW-1:0] frame_cnt;
   logic          ovf_err;
   logic          pad_err;

   int total = 0;
   int bad   = 0;

   serial_host_link #(.FIFO_DEPTH(2), .FRAME_CNT_W(CW)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_cpu_valid      (req_cpu_valid),
      .req_cpu_command    (req_cpu_command),
      .req_cpu_wr_data    (req_cpu_wr_data),
      .req_cpu_addr       (req_cpu_addr),
      .req_mem_req_ready  (req_mem_req_ready),
      .req_mem_resp_valid (req_mem_resp_valid),
      .req_mem_resp_data  (req_mem_resp_data),
      .link_out           (link_out),
      .link_in            (link_in),
      .resp_valid         (resp_valid),
      .resp_ready         (resp_ready),
      .resp_word          (resp_word),
      .resp_had_req       (resp_had_req),
      .phase              (phase),
      .frame_cnt          (frame_cnt),
      .ovf_err            (ovf_err),
      .pad_err            (pad_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v);
      req_valid          = v;
      req_cpu_valid      = v ? 4'hA : 4'h0;
      req_cpu_command    = v ? 4'h3 : 4'h0;
      req_cpu_wr_data    = v ? 4'h5 : 4'h0;
      req_cpu_addr       = v ? 24'h123456 : 24'h0;
      req_mem_req_ready  = v;
      req_mem_resp_valid = 1'b0;
      req_mem_resp_data  = v;
   endtask

   // Runs one whole frame from phase 0 back to phase 0.
   task automatic run_frame(input logic [11:0] lo, input logic [11:0] hi,
                            input logic rdy_body, input logic rdy_last);
      resp_ready = rdy_body;
      repeat (4) tick();
      link_in = lo;
      tick();
      link_in    = hi;
      resp_ready = rdy_last;
      tick();
      link_in = '0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_phase"},  32'(phase), 32'd0);
      check({tag, "_lout"},   32'(link_out), 32'd0);
      check({tag, "_rdy"},    32'(req_ready), 32'd0);
      check({tag, "_rvld"},   32'(resp_valid), 32'd0);
      check({tag, "_rword"},  32'(resp_word), 32'd0);
      check({tag, "_hreq"},   32'(resp_had_req), 32'd0);
      check({tag, "_fcnt"},   32'(frame_cnt), 32'd0);
      check({tag, "_ovf"},    32'(ovf_err), 32'd0);
      check({tag, "_pad"},    32'(pad_err), 32'd0);
   endtask

   logic [11:0] exp_lout [6];

   initial begin
      exp_lout[0] = 12'hA35;
      exp_lout[1] = 12'h456;
      exp_lout[2] = 12'h123;
      exp_lout[3] = 12'h005;
      exp_lout[4] = 12'h000;
      exp_lout[5] = 12'h000;

      reset_n    = 1'b0;
      set_req(1'b0);
      link_in    = '0;
      resp_ready = 1'b1;
      tick();
      tick();
      check_reset_state("rst");
      reset_n = 1'b1;

      // Idle frame 0
      for (int i = 0; i < 6; i++) begin
         check("idle_lout", 32'(link_out), 32'd0);
         tick();
      end
      check("f0_phase", 32'(phase), 32'd0);
      check("f0_rvld",  32'(resp_valid), 32'd1);
      check("f0_rword", 32'(resp_word), 32'd0);
      check("f0_hreq",  32'(resp_had_req), 32'd0);
      check("f0_fcnt",  32'(frame_cnt), 32'd1);

      // Frame 1: request held, accepted at phase 5
      set_req(1'b1);
      for (int i = 0; i < 5; i++) begin
         check("rdy_low", 32'(req_ready), 32'd0);
         tick();
      end
      check("ph5", 32'(phase), 32'd5);
      check("rdy_high", 32'(req_ready), 32'd1);
      tick();
      set_req(1'b0);

      // Frame 2: serialized request, response driven back
      for (int i = 0; i < 6; i++) begin
         check("req_lout", 32'(link_out), 32'(exp_lout[i]));
         if (i == 4) link_in = 12'h2CD;
         if (i == 5) link_in = 12'h0AB;
         tick();
      end
      link_in = '0;
      check("f2_lout",  32'(link_out), 32'd0);
      check("f2_rvld",  32'(resp_valid), 32'd1);
      check("f2_rword", 32'(resp_word), 32'h0AB2CD);
      check("f2_hreq",  32'(resp_had_req), 32'd1);
      check("f2_pad",   32'(pad_err), 32'd0);
      check("f2_fcnt",  32'(frame_cnt), 32'd3);

      // Frame 3: nonzero pad bits
      run_frame(12'h2CD, 12'hEAB, 1'b1, 1'b1);
      check("pad_set",   32'(pad_err), 32'd1);
      check("pad_rword", 32'(resp_word), 32'h0AB2CD);
      check("pad_hreq",  32'(resp_had_req), 32'd0);
      check("pad_fcnt",  32'(frame_cnt), 32'd4);

      // Frames 4-6: fill then overflow
      run_frame(12'h001, 12'h000, 1'b1, 1'b1);
      run_frame(12'h002, 12'h000, 1'b0, 1'b0);
      check("full_ovf0", 32'(ovf_err), 32'd0);
      run_frame(12'h003, 12'h000, 1'b0, 1'b0);
      check("ovf_set",   32'(ovf_err), 32'd1);
      check("ovf_fcnt",  32'(frame_cnt), 32'd7);
      check("ovf_head0", 32'(resp_word), 32'h000001);
      resp_ready = 1'b1;
      tick();
      check("ovf_head1", 32'(resp_word), 32'h000002);
      tick();
      check("ovf_empty", 32'(resp_valid), 32'd0);
      repeat (4) tick();

      // Frames 8-9: full with pop at the push edge
      run_frame(12'h004, 12'h000, 1'b0, 1'b0);
      run_frame(12'h005, 12'h000, 1'b0, 1'b1);
      resp_ready = 1'b0;
      check("simul_fcnt",  32'(frame_cnt), 32'd10);
      check("simul_head0", 32'(resp_word), 32'h000004);
      resp_ready = 1'b1;
      tick();
      check("simul_head1", 32'(resp_word), 32'h000005);
      check("simul_vld",   32'(resp_valid), 32'd1);
      repeat (5) tick();

      // Mid-frame reset during phase 2 of a request frame
      set_req(1'b1);
      repeat (6) tick();
      set_req(1'b0);
      check("mid_lout0", 32'(link_out), 32'hA35);
      tick();
      tick();
      check("mid_ph2", 32'(phase), 32'd2);
      reset_n = 1'b0;
      #1;
      check_reset_state("mid");
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("post_lout", 32'(link_out), 32'd0);
         if (i == 5) check("post_nostale", 32'(resp_valid), 32'd0);
         tick();
      end
      check("post_rvld", 32'(resp_valid), 32'd1);
      check("post_hreq", 32'(resp_had_req), 32'd0);
      check("post_word", 32'(resp_word), 32'd0);
      check("post_fcnt", 32'(frame_cnt), 32'd1);

      // Counter wrap
      for (int i = 0; i < 254; i++) run_frame(12'h000, 12'h000, 1'b1, 1'b1);
      check("wrap_pre", 32'(frame_cnt), 32'd255);
      run_frame(12'h000, 12'h000, 1'b1, 1'b1);
      check("wrap_zero", 32'(frame_cnt), 32'd0);
      check("wrap_ovf",  32'(ovf_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
